// File: rtl/wb_regfile_if.sv
// Bus bundle for wb_regfile: writeback commit, issue tracking, the two decode read ports and status.
// The slave side belongs to the register file; the master side belongs to the pipeline or the bench.
interface wb_regfile_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic                   wb_regwrite;
   logic [ADDR_W-1:0]      wb_rd;
   logic [DATA_W-1:0]      wb_data;
   logic                   iss_valid;
   logic                   iss_regwrite;
   logic [ADDR_W-1:0]      iss_rd;
   logic [ADDR_W-1:0]      rs1_addr;
   logic [ADDR_W-1:0]      rs2_addr;
   logic [DATA_W-1:0]      rs1_data;
   logic [DATA_W-1:0]      rs2_data;
   logic                   rs1_busy;
   logic                   rs2_busy;
   logic                   stall;
   logic [2**ADDR_W-1:0]   busy_mask;
   logic                   err_ovf;
   logic                   err_unf;

   modport master (
      output wb_regwrite, wb_rd, wb_data, iss_valid, iss_regwrite, iss_rd, rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_mask, err_ovf, err_unf
   );

   modport slave (
      input  wb_regwrite, wb_rd, wb_data, iss_valid, iss_regwrite, iss_rd, rs1_addr, rs2_addr,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_mask, err_ovf, err_unf
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback register file with a per-register pending-write scoreboard for hazard stalls.
// Defining WB_BYPASS_EN enables same-cycle write-through on the read ports and busy qualification.
module wb_regfile #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 2
) (
   input logic          clk,
   input logic          rst,
   wb_regfile_if.slave  bus
);
   localparam int NREG = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0] r_regs [NREG];
   logic [CNT_W-1:0]  r_cnt  [NREG];
   logic [NREG-1:0]   r_busy_mask;
   logic              r_err_ovf;
   logic              r_err_unf;

   logic              w_wr_en;
   logic              w_iss_en;
   logic [NREG-1:0]   w_inc;
   logic [NREG-1:0]   w_dec;
   logic [NREG-1:0]   w_ovf_hit;
   logic [NREG-1:0]   w_unf_hit;
   logic [NREG-1:0]   w_nz_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt [NREG];

   assign w_wr_en  = bus.wb_regwrite && (bus.wb_rd != '0);
   assign w_iss_en = bus.iss_valid && bus.iss_regwrite && (bus.iss_rd != '0);

   // r0 is excluded from the loop so its counter stays at zero forever
   always_comb begin
      w_inc     = '0;
      w_dec     = '0;
      w_ovf_hit = '0;
      w_unf_hit = '0;
      w_nz_nxt  = '0;
      for (int i = 0; i < NREG; i++) w_cnt_nxt[i] = r_cnt[i];
      if (w_iss_en) w_inc[bus.iss_rd] = 1'b1;
      if (w_wr_en)  w_dec[bus.wb_rd]  = 1'b1;
      for (int i = 1; i < NREG; i++) begin
         if (w_inc[i] && !w_dec[i]) begin
            if (r_cnt[i] == CNT_MAX) w_ovf_hit[i] = 1'b1;
            else                     w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         end else if (w_dec[i] && !w_inc[i]) begin
            if (r_cnt[i] == '0) w_unf_hit[i] = 1'b1;
            else                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
         end
         w_nz_nxt[i] = (w_cnt_nxt[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
            r_cnt[i]  <= '0;
         end
         r_busy_mask <= '0;
         r_err_ovf   <= 1'b0;
         r_err_unf   <= 1'b0;
      end else begin
         if (w_wr_en) r_regs[bus.wb_rd] <= bus.wb_data;
         for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_nxt[i];
         r_busy_mask <= w_nz_nxt;
         if (|w_ovf_hit) r_err_ovf <= 1'b1;
         if (|w_unf_hit) r_err_unf <= 1'b1;
      end
   end

   logic [DATA_W-1:0] w_rs1_arr;
   logic [DATA_W-1:0] w_rs2_arr;
   logic [CNT_W-1:0]  w_rs1_cnt;
   logic [CNT_W-1:0]  w_rs2_cnt;

   assign w_rs1_arr = r_regs[bus.rs1_addr];
   assign w_rs2_arr = r_regs[bus.rs2_addr];
   assign w_rs1_cnt = r_cnt[bus.rs1_addr];
   assign w_rs2_cnt = r_cnt[bus.rs2_addr];

`ifdef WB_BYPASS_EN
   logic w_rs1_hit;
   logic w_rs2_hit;

   // a matching writeback resolves the last pending write this very cycle
   assign w_rs1_hit    = w_wr_en && (bus.wb_rd == bus.rs1_addr);
   assign w_rs2_hit    = w_wr_en && (bus.wb_rd == bus.rs2_addr);
   assign bus.rs1_data = w_rs1_hit ? bus.wb_data : w_rs1_arr;
   assign bus.rs2_data = w_rs2_hit ? bus.wb_data : w_rs2_arr;
   assign bus.rs1_busy = (w_rs1_cnt > CNT_W'(1)) || ((w_rs1_cnt == CNT_W'(1)) && !w_rs1_hit);
   assign bus.rs2_busy = (w_rs2_cnt > CNT_W'(1)) || ((w_rs2_cnt == CNT_W'(1)) && !w_rs2_hit);
`else
   assign bus.rs1_data = w_rs1_arr;
   assign bus.rs2_data = w_rs2_arr;
   assign bus.rs1_busy = (w_rs1_cnt != '0);
   assign bus.rs2_busy = (w_rs2_cnt != '0);
`endif

   assign bus.stall     = bus.rs1_busy || bus.rs2_busy;
   assign bus.busy_mask = r_busy_mask;
   assign bus.err_ovf   = r_err_ovf;
   assign bus.err_unf   = r_err_unf;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, reset corner sequence and random traffic
// checked against an array/integer reference model of the register file and pending counts.
module tb_wb_regfile;
`ifdef WB_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_regfile_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   wb_regfile #(.DATA_W(8), .ADDR_W(3), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_reg [8];
   int         m_cnt [8];
   bit         m_ovf;
   bit         m_unf;

   typedef struct {
      logic       wr;
      logic [2:0] rd;
      logic [7:0] d;
      logic       iv;
      logic [2:0] ird;
      logic [2:0] a1;
      logic [2:0] a2;
      logic [7:0] e1;
      logic       b1;
      logic [7:0] e2;
      logic       b2;
      logic       st;
      logic [7:0] mask;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t tv [21];

   function automatic vec_t mk(logic wr, logic [2:0] rd, logic [7:0] d, logic iv, logic [2:0] ird,
                               logic [2:0] a1, logic [2:0] a2, logic [7:0] e1, logic b1,
                               logic [7:0] e2, logic b2, logic st, logic [7:0] mask,
                               logic ovf, logic unf);
      vec_t v;
      v.wr = wr; v.rd = rd; v.d = d; v.iv = iv; v.ird = ird; v.a1 = a1; v.a2 = a2;
      v.e1 = e1; v.b1 = b1; v.e2 = e2; v.b2 = b2; v.st = st; v.mask = mask;
      v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_data(int a);
      if (a == 0) return 8'h00;
      if (BP && bus.wb_regwrite && (int'(bus.wb_rd) == a)) return bus.wb_data;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(int a);
      logic wb_hit;
      if (a == 0) return 1'b0;
      wb_hit = bus.wb_regwrite && (int'(bus.wb_rd) == a);
      if (BP) return (m_cnt[a] > 1) || ((m_cnt[a] == 1) && !wb_hit);
      return m_cnt[a] != 0;
   endfunction

   function automatic logic [7:0] exp_mask();
      logic [7:0] m;
      m = 8'h00;
      for (int i = 1; i < 8; i++) m[i] = (m_cnt[i] != 0);
      return m;
   endfunction

   task automatic model_update();
      int wi;
      int ii;
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_reg[i] = 8'h00;
            m_cnt[i] = 0;
         end
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         wi = (bus.wb_regwrite && bus.wb_rd != 0) ? int'(bus.wb_rd) : -1;
         ii = (bus.iss_valid && bus.iss_regwrite && bus.iss_rd != 0) ? int'(bus.iss_rd) : -1;
         if (wi > 0) m_reg[wi] = bus.wb_data;
         if (ii > 0 && ii != wi) begin
            if (m_cnt[ii] == 3) m_ovf = 1'b1;
            else                m_cnt[ii]++;
         end
         if (wi > 0 && wi != ii) begin
            if (m_cnt[wi] == 0) m_unf = 1'b1;
            else                m_cnt[wi]--;
         end
      end
   endtask

   task automatic check_comb();
      logic b1;
      logic b2;
      b1 = exp_busy(int'(bus.rs1_addr));
      b2 = exp_busy(int'(bus.rs2_addr));
      chk("m_rs1_data", 32'(bus.rs1_data), 32'(exp_data(int'(bus.rs1_addr))));
      chk("m_rs2_data", 32'(bus.rs2_data), 32'(exp_data(int'(bus.rs2_addr))));
      chk("m_rs1_busy", 32'(bus.rs1_busy), 32'(b1));
      chk("m_rs2_busy", 32'(bus.rs2_busy), 32'(b2));
      chk("m_stall", 32'(bus.stall), 32'(b1 | b2));
   endtask

   task automatic check_post();
      chk("m_busy_mask", 32'(bus.busy_mask), 32'(exp_mask()));
      chk("m_err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
      chk("m_err_unf", 32'(bus.err_unf), 32'(m_unf));
   endtask

   task automatic cycle();
      @(negedge clk);
      check_comb();
      @(posedge clk);
      model_update();
      #1;
      check_post();
   endtask

   task automatic drive(input logic wr, input logic [2:0] rd, input logic [7:0] d,
                        input logic iv, input logic [2:0] ird,
                        input logic [2:0] a1, input logic [2:0] a2);
      bus.wb_regwrite  = wr;
      bus.wb_rd        = rd;
      bus.wb_data      = d;
      bus.iss_valid    = iv;
      bus.iss_regwrite = iv;
      bus.iss_rd       = ird;
      bus.rs1_addr     = a1;
      bus.rs2_addr     = a2;
   endtask

   initial begin
      tv[0]  = mk(0, 0, 8'h00, 1, 3, 3, 0, 8'h00, 0, 8'h00, 0, 0, 8'h08, 0, 0);
      tv[1]  = mk(0, 0, 8'h00, 0, 0, 3, 0, 8'h00, 1, 8'h00, 0, 1, 8'h08, 0, 0);
      tv[2]  = mk(1, 3, 8'hA5, 0, 0, 3, 0, BP ? 8'hA5 : 8'h00, ~BP, 8'h00, 0, ~BP, 8'h00, 0, 0);
      tv[3]  = mk(0, 0, 8'h00, 0, 0, 3, 0, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      tv[4]  = mk(0, 0, 8'h00, 1, 5, 5, 0, 8'h00, 0, 8'h00, 0, 0, 8'h20, 0, 0);
      tv[5]  = mk(0, 0, 8'h00, 1, 5, 5, 0, 8'h00, 1, 8'h00, 0, 1, 8'h20, 0, 0);
      tv[6]  = mk(1, 5, 8'h11, 0, 0, 5, 0, BP ? 8'h11 : 8'h00, 1, 8'h00, 0, 1, 8'h20, 0, 0);
      tv[7]  = mk(0, 0, 8'h00, 0, 0, 5, 0, 8'h11, 1, 8'h00, 0, 1, 8'h20, 0, 0);
      tv[8]  = mk(1, 5, 8'h22, 0, 0, 5, 0, BP ? 8'h22 : 8'h11, ~BP, 8'h00, 0, ~BP, 8'h00, 0, 0);
      tv[9]  = mk(0, 0, 8'h00, 1, 2, 2, 0, 8'h00, 0, 8'h00, 0, 0, 8'h04, 0, 0);
      tv[10] = mk(1, 2, 8'h5A, 1, 2, 2, 0, BP ? 8'h5A : 8'h00, ~BP, 8'h00, 0, ~BP, 8'h04, 0, 0);
      tv[11] = mk(0, 0, 8'h00, 0, 0, 2, 0, 8'h5A, 1, 8'h00, 0, 1, 8'h04, 0, 0);
      tv[12] = mk(1, 2, 8'h5B, 0, 0, 2, 0, BP ? 8'h5B : 8'h5A, ~BP, 8'h00, 0, ~BP, 8'h00, 0, 0);
      tv[13] = mk(1, 4, 8'h3C, 0, 0, 4, 4, BP ? 8'h3C : 8'h00, 0, BP ? 8'h3C : 8'h00, 0, 0,
                  8'h00, 0, 1);
      tv[14] = mk(0, 0, 8'h00, 0, 0, 4, 0, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 0, 1);
      tv[15] = mk(0, 0, 8'h00, 1, 6, 6, 0, 8'h00, 0, 8'h00, 0, 0, 8'h40, 0, 1);
      tv[16] = mk(0, 0, 8'h00, 1, 6, 6, 0, 8'h00, 1, 8'h00, 0, 1, 8'h40, 0, 1);
      tv[17] = mk(0, 0, 8'h00, 1, 6, 6, 0, 8'h00, 1, 8'h00, 0, 1, 8'h40, 0, 1);
      tv[18] = mk(0, 0, 8'h00, 1, 6, 6, 0, 8'h00, 1, 8'h00, 0, 1, 8'h40, 1, 1);
      tv[19] = mk(1, 0, 8'hFF, 0, 0, 0, 6, 8'h00, 0, 8'h00, 1, 1, 8'h40, 1, 1);
      tv[20] = mk(0, 0, 8'h00, 0, 0, 0, 2, 8'h00, 0, 8'h5B, 0, 0, 8'h40, 1, 1);

      // initial reset: DUT state is unknown until the first edge, so no checks yet
      drive(0, 0, 8'h00, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      model_update();
      #1;
      cycle();
      rst = 1'b0;

      // reset state read-back over every address
      for (int a = 0; a < 8; a++) begin
         drive(0, 0, 8'h00, 0, 0, 3'(a), 3'(7 - a));
         cycle();
      end

      // directed vector table
      for (int k = 0; k < 21; k++) begin
         drive(tv[k].wr, tv[k].rd, tv[k].d, tv[k].iv, tv[k].ird, tv[k].a1, tv[k].a2);
         @(negedge clk);
         chk($sformatf("v%0d_rs1_data", k), 32'(bus.rs1_data), 32'(tv[k].e1));
         chk($sformatf("v%0d_rs1_busy", k), 32'(bus.rs1_busy), 32'(tv[k].b1));
         chk($sformatf("v%0d_rs2_data", k), 32'(bus.rs2_data), 32'(tv[k].e2));
         chk($sformatf("v%0d_rs2_busy", k), 32'(bus.rs2_busy), 32'(tv[k].b2));
         chk($sformatf("v%0d_stall", k), 32'(bus.stall), 32'(tv[k].st));
         check_comb();
         @(posedge clk);
         model_update();
         #1;
         chk($sformatf("v%0d_busy_mask", k), 32'(bus.busy_mask), 32'(tv[k].mask));
         chk($sformatf("v%0d_err_ovf", k), 32'(bus.err_ovf), 32'(tv[k].ovf));
         chk($sformatf("v%0d_err_unf", k), 32'(bus.err_unf), 32'(tv[k].unf));
         check_post();
      end

      // reset with r1 pending and a same-cycle writeback to r1
      drive(1, 1, 8'h99, 0, 0, 1, 0);
      cycle();
      drive(0, 0, 8'h00, 1, 1, 1, 0);
      cycle();
      chk("rst_pre_mask", 32'(bus.busy_mask), 32'h42);
      rst = 1'b1;
      drive(1, 1, 8'h77, 0, 0, 1, 0);
      cycle();
      rst = 1'b0;
      chk("rst_mask", 32'(bus.busy_mask), 32'h00);
      chk("rst_ovf", 32'(bus.err_ovf), 32'h0);
      chk("rst_unf", 32'(bus.err_unf), 32'h0);
      drive(0, 0, 8'h00, 0, 0, 1, 6);
      #1;
      chk("rst_r1_data", 32'(bus.rs1_data), 32'h00);
      chk("rst_r1_busy", 32'(bus.rs1_busy), 32'h0);
      chk("rst_stall", 32'(bus.stall), 32'h0);
      cycle();

      // randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 249) == 0);
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         bus.iss_regwrite = 1'($urandom_range(0, 3) != 0);
         cycle();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
